mux_console_target: RTL



---
 rtl/mux_console_target.sv | 348 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mux_console_target.sv
// mux_console_target: CPU6 bus responder exposing a status/data register pair.
// Transmit bytes queue in a 4-entry FIFO and leave on an 8N1 line (txd).
// Received 8N1 frames (rxd) land in a holding register that software polls.
module mux_console_target #(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic        writeEnBus,
  input  logic        readEnBus,
  input  logic [7:0]  dataFromCpu,
  output logic [7:0]  dataToCpu,
  output logic        selected,
  output logic        txd,
  input  logic        rxd
);

  localparam logic [15:0] STAT_ADDR = BASE_ADDR;
  localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Bus decode
  logic stat_sel_s, data_sel_s, wr_stat_s, wr_data_s, rd_data_s;
  logic [7:0] status_s;

  // FIFO
  logic [7:0] fifo_mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       push_ok_s, pop_s;
  logic [7:0] head_s;

  // TX path
  tx_state_e  tx_state_q, tx_state_d;
  logic [15:0] tx_timer_q, tx_timer_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic        tx_idle_s, tx_not_full_s;

  // RX path
  logic        rx_meta_q, rxs_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_timer_q, rx_timer_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_ok_s, rx_bad_s;

  // Flags and holding register
  logic       rx_ready_q, rx_ready_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] rx_hold_q, rx_hold_d;

  assign stat_sel_s    = (addressBus == STAT_ADDR);
  assign data_sel_s    = (addressBus == DATA_ADDR);
  assign wr_stat_s     = writeEnBus & stat_sel_s;
  assign wr_data_s     = writeEnBus & data_sel_s;
  assign rd_data_s     = readEnBus & data_sel_s;
  assign selected      = stat_sel_s | data_sel_s;
  assign tx_not_full_s = (count_q != 3'd4);
  assign tx_idle_s     = (tx_state_q == TX_IDLE) && (count_q == 3'd0);
  assign status_s      = {3'b000, tx_idle_s, frame_err_q, overrun_q, tx_not_full_s, rx_ready_q};
  assign head_s        = fifo_mem_q[rd_ptr_q];
  assign txd           = txd_q;
  // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
  assign push_ok_s     = wr_data_s & (tx_not_full_s | pop_s);

  // Zero-latency read mux; the CPU samples dataInBus combinationally.
  always_comb begin
    dataToCpu = 8'h00;
    case ({stat_sel_s, data_sel_s})
      2'b10:   dataToCpu = status_s;
      2'b01:   dataToCpu = rx_hold_q;
      default: dataToCpu = 8'h00;
    endcase
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointer registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= 8'h00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok_s) begin
        fifo_mem_q[wr_ptr_q] <= dataFromCpu;
      end
    end
  end

  // TX FSM next-state: start bit, 8 data bits LSB first, stop bit; txd is registered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = tx_timer_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    pop_s      = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (count_q != 3'd0) begin
          pop_s      = 1'b1;
          tx_shift_d = head_s;
          tx_timer_d = 16'd0;
          tx_state_d = TX_START;
          txd_d      = 1'b0;
        end else begin
          txd_d = 1'b1;
        end
      end
      TX_START: begin
        if (tx_timer_q == BIT_LAST) begin
          tx_timer_d = 16'd0;
          tx_idx_d   = 3'd0;
          tx_state_d = TX_DATA;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_timer_d = tx_timer_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_timer_q == BIT_LAST) begin
          tx_timer_d = 16'd0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_idx_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            txd_d    = tx_shift_q[1];
          end
        end else begin
          tx_timer_d = tx_timer_q + 16'd1;
        end
      end
      TX_STOP: begin
        txd_d = 1'b1;
        if (tx_timer_q == BIT_LAST) begin
          tx_timer_d = 16'd0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_timer_d = tx_timer_q + 16'd1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  // TX FSM state register; reset aborts any frame and parks txd high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_timer_q <= 16'd0;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_timer_q <= tx_timer_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // Two-flop synchronizer for the asynchronous receive line, idling high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  // RX FSM next-state: half-bit start qualification, then samples at bit centres.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_timer_d = rx_timer_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_ok_s    = 1'b0;
    rx_bad_s   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          rx_state_d = RX_START;
          rx_timer_d = 16'd0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_timer_q == HALF_LAST) begin
          rx_timer_d = 16'd0;
          if (rxs_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_idx_d   = 3'd0;
          end
        end else begin
          rx_timer_d = rx_timer_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_timer_q == BIT_LAST) begin
          rx_timer_d = 16'd0;
          rx_shift_d = {rxs_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_timer_d = rx_timer_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_timer_q == BIT_LAST) begin
          rx_timer_d = 16'd0;
          rx_state_d = RX_IDLE;
          if (rxs_q) begin
            rx_ok_s = 1'b1;
          end else begin
            rx_bad_s = 1'b1;
          end
        end else begin
          rx_timer_d = rx_timer_q + 16'd1;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // RX FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_timer_q <= 16'd0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_state_q <= rx_state_d;
      rx_timer_q <= rx_timer_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Status flag next-state; hardware set events win over software clears.
  always_comb begin
    rx_ready_d  = rx_ready_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    rx_hold_d   = rx_hold_q;
    if (rx_ok_s) begin
      rx_ready_d = 1'b1;
      rx_hold_d  = rx_shift_q;
    end else if (rd_data_s) begin
      rx_ready_d = 1'b0;
    end else begin
      rx_ready_d = rx_ready_q;
    end
    if (rx_ok_s && rx_ready_q) begin
      overrun_d = 1'b1;
    end else if (wr_stat_s && dataFromCpu[2]) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (rx_bad_s) begin
      frame_err_d = 1'b1;
    end else if (wr_stat_s && dataFromCpu[3]) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Status flag and receive holding registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_ready_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_hold_q   <= 8'h00;
    end else begin
      rx_ready_q  <= rx_ready_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_hold_q   <= rx_hold_d;
    end
  end

endmodule
